// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - bus interface for the multi-port register file
//
// Groups every regfile_mp signal except clk/rst_n.
//   rs_addr   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rs_data   read data, port i at [i*DATA_W +: DATA_W]
//   rs_busy   per read port: addressed register has a pending write
//   we0/wa0/wd0, we1/wa1/wd1   write ports (port 1 wins on collision)
//   iss_valid/iss_rd           destination register of an issued instruction
//   flush                      clear all busy bits
//   busy_vec                   raw scoreboard state
// Modports: master = pipeline side (drives addresses/writes/issue),
//           slave  = register file side.
interface regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);
    logic [NUM_RD*ADDR_W-1:0] rs_addr;
    logic [NUM_RD*DATA_W-1:0] rs_data;
    logic [NUM_RD-1:0]        rs_busy;
    logic                     we0;
    logic [ADDR_W-1:0]        wa0;
    logic [DATA_W-1:0]        wd0;
    logic                     we1;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd1;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_rd;
    logic                     flush;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output rs_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_rd, flush,
        input  rs_data, rs_busy, busy_vec
    );

    modport slave (
        input  rs_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_rd, flush,
        output rs_data, rs_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with per-register busy scoreboard
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears registers and busy bits)
//   bus    regfile_mp_if.slave: NUM_RD combinational read ports with busy flags,
//          two write ports (port 1 higher priority), issue/flush scoreboard
//          controls and the raw busy vector.
// Register 0 reads as zero, ignores writes and is never marked busy.
// Optional feature: define REGFILE_MP_BYPASS_EN for same-cycle write-to-read
// forwarding of data and of the busy clear.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]      r_busy;
    logic [NUM_REGS-1:0]      w_busy_nxt;
    logic [NUM_RD*DATA_W-1:0] w_rs_data;
    logic [NUM_RD-1:0]        w_rs_busy;

    // Port 1 is applied after port 0 so it wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            if (bus.we0 && (bus.wa0 != '0)) begin
                r_regs[bus.wa0] <= bus.wd0;
            end
            if (bus.we1 && (bus.wa1 != '0)) begin
                r_regs[bus.wa1] <= bus.wd1;
            end
        end
    end

    // Order matters: retire-clears, then flush, then the issue set, so a new
    // producer issuing as the old one retires (or during a flush) stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.we0) begin
            w_busy_nxt[bus.wa0] = 1'b0;
        end
        if (bus.we1) begin
            w_busy_nxt[bus.wa1] = 1'b0;
        end
        if (bus.flush) begin
            w_busy_nxt = '0;
        end
        if (bus.iss_valid) begin
            w_busy_nxt[bus.iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        w_rs_data = '0;
        w_rs_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] a;
            a = bus.rs_addr[i*ADDR_W +: ADDR_W];
            if (a != '0) begin
                w_rs_data[i*DATA_W +: DATA_W] = r_regs[a];
                w_rs_busy[i]                  = r_busy[a];
`ifdef REGFILE_MP_BYPASS_EN
                // Port 1 checked last so its data takes precedence.
                if (bus.we0 && (bus.wa0 == a)) begin
                    w_rs_data[i*DATA_W +: DATA_W] = bus.wd0;
                end
                if (bus.we1 && (bus.wa1 == a)) begin
                    w_rs_data[i*DATA_W +: DATA_W] = bus.wd1;
                end
                // The forwarded clear is suppressed when a new producer
                // issues to the same register this cycle.
                if (((bus.we0 && (bus.wa0 == a)) || (bus.we1 && (bus.wa1 == a))) &&
                    !(bus.iss_valid && (bus.iss_rd == a))) begin
                    w_rs_busy[i] = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.rs_data  = w_rs_data;
    assign bus.rs_busy  = w_rs_busy;
    assign bus.busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int ADDR_W   = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    regfile_mp_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus ();

    regfile_mp #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we0       = 1'b0;
        bus.wa0       = '0;
        bus.wd0       = '0;
        bus.we1       = 1'b0;
        bus.wa1       = '0;
        bus.wd1       = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        bus.rs_addr = {a1, a0};
        #1;
    endtask

    task automatic wr0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.we0 = 1'b1;
        bus.wa0 = a;
        bus.wd0 = d;
    endtask

    task automatic wr1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.we1 = 1'b1;
        bus.wa1 = a;
        bus.wd1 = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = a;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        idle();
        bus.rs_addr = '0;

        // Reset: everything zero during and after reset.
        repeat (3) tick();
        chk("rst_busy_vec_held", {32'd0, bus.busy_vec}, 64'd0);
        rd(5'd1, 5'd31);
        chk("rst_data_held", bus.rs_data, 64'd0);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < NUM_REGS; a += 2) begin
            rd(a[4:0], 5'(a + 1));
            chk("rst_data", bus.rs_data, 64'd0);
            chk("rst_rs_busy", {62'd0, bus.rs_busy}, 64'd0);
        end
        chk("rst_busy_vec", {32'd0, bus.busy_vec}, 64'd0);

        // Register 0: write and issue are ignored.
        wr0(5'd0, 32'hDEADBEEF);
        issue(5'd0);
        tick();
        idle();
        rd(5'd0, 5'd0);
        chk("r0_read", bus.rs_data, 64'd0);
        chk("r0_busy_vec", {32'd0, bus.busy_vec}, 64'd0);
        chk("r0_rs_busy", {62'd0, bus.rs_busy}, 64'd0);

        // Dual write collision: port 1 wins.
        wr0(5'd5, 32'h1111);
        wr1(5'd5, 32'h2222);
        tick();
        idle();
        rd(5'd5, 5'd5);
        chk("collision", bus.rs_data, {32'h2222, 32'h2222});

        // Bypass: prior value 0x77 in r7, then same-cycle write/read.
        wr0(5'd7, 32'h77);
        tick();
        idle();
        wr1(5'd7, 32'hCAFE0007);
        rd(5'd7, 5'd0);
`ifdef REGFILE_MP_BYPASS_EN
        chk("bypass_same_cycle", bus.rs_data, {32'd0, 32'hCAFE0007});
`else
        chk("bypass_same_cycle", bus.rs_data, {32'd0, 32'h77});
`endif
        tick();
        idle();
        rd(5'd7, 5'd0);
        chk("bypass_next_cycle", bus.rs_data, {32'd0, 32'hCAFE0007});

        // Scoreboard: issue 9, retire+reissue keeps busy, retire alone clears.
        issue(5'd9);
        tick();
        idle();
        rd(5'd9, 5'd5);
        chk("sb_set_vec", {32'd0, bus.busy_vec}, 64'h200);
        chk("sb_set_rs_busy", {62'd0, bus.rs_busy}, 64'd1);
        wr0(5'd9, 32'h99);
        issue(5'd9);
        #1;
        chk("sb_reissue_rs_busy", {62'd0, bus.rs_busy}, 64'd1);
        tick();
        idle();
        #1;
        chk("sb_reissue_vec", {32'd0, bus.busy_vec}, 64'h200);
        wr0(5'd9, 32'h9A);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("sb_clear_same_cycle", {62'd0, bus.rs_busy}, 64'd0);
`else
        chk("sb_clear_same_cycle", {62'd0, bus.rs_busy}, 64'd1);
`endif
        tick();
        idle();
        #1;
        chk("sb_clear_vec", {32'd0, bus.busy_vec}, 64'd0);
        chk("sb_clear_data", bus.rs_data, {32'h2222, 32'h9A});

        // Flush: write data, mark 3/4/12 busy, flush with issue of 20.
        wr0(5'd3, 32'h33);
        wr1(5'd4, 32'h44);
        tick();
        idle();
        wr0(5'd12, 32'hCC);
        issue(5'd3);
        tick();
        idle();
        issue(5'd4);
        tick();
        idle();
        issue(5'd12);
        issue(5'd12);
        tick();
        idle();
        #1;
        chk("flush_pre_vec", {32'd0, bus.busy_vec}, 64'h1018);
        bus.flush = 1'b1;
        issue(5'd20);
        tick();
        idle();
        rd(5'd3, 5'd4);
        chk("flush_vec", {32'd0, bus.busy_vec}, 64'h0010_0000);
        chk("flush_data_3_4", bus.rs_data, {32'h44, 32'h33});
        rd(5'd12, 5'd20);
        chk("flush_data_12", bus.rs_data, {32'd0, 32'hCC});
        chk("flush_rs_busy", {62'd0, bus.rs_busy}, 64'b10);

        // Asynchronous reset mid-cycle wipes data and busy before the next edge.
        rd(5'd3, 5'd12);
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", bus.rs_data, 64'd0);
        chk("async_rst_vec", {32'd0, bus.busy_vec}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(5'd4, 5'd7);
        chk("post_rst_data", bus.rs_data, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
